// File: rtl/step_ctrl.sv
// Execution controller: turns debounced step/run buttons into a one-cycle
// datapath enable, with divided free-run, address breakpoint and flag halt.
module step_ctrl #(
  parameter int ADDR_W  = 5,
  parameter int CNT_W   = 16,
  parameter int RUN_DIV = 25
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clken,
  input  logic              btn_step,
  input  logic              btn_run,
  input  logic [ADDR_W-1:0] endereco,
  input  logic [3:0]        flags,
  input  logic [3:0]        halt_mask,
  input  logic              bkpt_en,
  input  logic [ADDR_W-1:0] bkpt_addr,
  output logic              step_en,
  output logic              running,
  output logic              halted,
  output logic [CNT_W-1:0]  step_count
);

  localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               armed_q, armed_d;
  logic               step_en_q, step_en_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               btn_step_q, btn_run_q;
  logic               step_rise, run_rise, stop_hit;

  assign step_rise = btn_step & ~btn_step_q;
  assign run_rise  = btn_run & ~btn_run_q;
  // armed stays low until the first run step, so a run started on the
  // breakpoint address or with a masked flag already set still advances.
  assign stop_hit  = armed_q & ((bkpt_en & (endereco == bkpt_addr)) |
                                (|(flags & halt_mask)));

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    armed_d   = armed_q;
    step_en_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run_rise) begin
          state_d = S_RUN;
          div_d   = '0;
          armed_d = 1'b0;
        end else if (step_rise) begin
          step_en_d = 1'b1;
        end
      end
      S_RUN: begin
        if (run_rise) begin
          state_d = S_IDLE;
        end else if (stop_hit) begin
          state_d = S_HALT;
        end else if (clken) begin
          if (div_q == DIV_W'(RUN_DIV - 1)) begin
            step_en_d = 1'b1;
            div_d     = '0;
            armed_d   = 1'b1;
          end else begin
            div_d = div_q + 1'b1;
          end
        end
      end
      S_HALT: begin
        if (run_rise) begin
          state_d = S_RUN;
          div_d   = '0;
          armed_d = 1'b0;
        end else if (step_rise) begin
          step_en_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    cnt_d = cnt_q + CNT_W'(step_en_d);
  end

  always_ff @(posedge clock) begin
    // Edge registers load even in reset so a held button never steps.
    btn_step_q <= btn_step;
    btn_run_q  <= btn_run;
    if (reset) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      armed_q   <= 1'b0;
      step_en_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      armed_q   <= armed_d;
      step_en_q <= step_en_d;
      cnt_q     <= cnt_d;
    end
  end

  assign step_en    = step_en_q;
  assign running    = (state_q == S_RUN);
  assign halted     = (state_q == S_HALT);
  assign step_count = cnt_q;

endmodule

// File: tb/tb_step_ctrl.sv
// Self-checking bench for step_ctrl: directed scenarios plus randomized
// traffic compared against a behavioural model of the controller.
module tb_step_ctrl;
  localparam int ADDR_W  = 5;
  localparam int CNT_W   = 8;
  localparam int RUN_DIV = 25;
  localparam int CMAX    = (1 << CNT_W);

  logic              clock = 1'b0;
  logic              reset, clken, btn_step, btn_run, bkpt_en;
  logic [ADDR_W-1:0] endereco, bkpt_addr;
  logic [3:0]        flags, halt_mask;
  logic              step_en, running, halted;
  logic [CNT_W-1:0]  step_count;

  int checks = 0;
  int failures = 0;

  // Behavioural model: mode 0=idle 1=run 2=halt; m_ticks counts clken ticks
  // since the last run step.
  int m_mode, m_ticks, m_count;
  bit m_armed, m_ps, m_pr, m_en;

  step_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .RUN_DIV(RUN_DIV)) dut (
    .clock(clock), .reset(reset), .clken(clken), .btn_step(btn_step),
    .btn_run(btn_run), .endereco(endereco), .flags(flags),
    .halt_mask(halt_mask), .bkpt_en(bkpt_en), .bkpt_addr(bkpt_addr),
    .step_en(step_en), .running(running), .halted(halted),
    .step_count(step_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    bit sr, rr, hit, fire;
    @(posedge clock);
    if (reset) begin
      m_mode = 0; m_ticks = 0; m_armed = 0; m_en = 0; m_count = 0;
    end else begin
      sr   = btn_step && !m_ps;
      rr   = btn_run && !m_pr;
      hit  = m_armed && ((bkpt_en && endereco == bkpt_addr) || ((flags & halt_mask) != 0));
      fire = 0;
      if (m_mode == 0) begin
        if (rr) begin m_mode = 1; m_ticks = 0; m_armed = 0; end
        else if (sr) fire = 1;
      end else if (m_mode == 1) begin
        if (rr) m_mode = 0;
        else if (hit) m_mode = 2;
        else if (clken) begin
          m_ticks++;
          if (m_ticks == RUN_DIV) begin fire = 1; m_ticks = 0; m_armed = 1; end
        end
      end else begin
        if (rr) begin m_mode = 1; m_ticks = 0; m_armed = 0; end
        else if (sr) begin fire = 1; m_mode = 0; end
      end
      m_en = fire;
      m_count = (m_count + int'(fire)) % CMAX;
    end
    m_ps = btn_step;
    m_pr = btn_run;
    #1;
  endtask

  task automatic test_reset();
    reset = 1; btn_step = 1; btn_run = 0; clken = 0; flags = 0; halt_mask = 0;
    bkpt_en = 0; bkpt_addr = 0; endereco = 0;
    tick(); tick();
    checks++;
    if (step_en !== 1'b0 || running !== 1'b0 || halted !== 1'b0 || step_count !== '0) begin
      failures++;
      $display("FAIL reset_state: step_en=%b running=%b halted=%b count=%0d, want 0/0/0/0",
               step_en, running, halted, step_count);
    end
    reset = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (step_en !== 1'b0) begin
        failures++;
        $display("FAIL held_step_after_reset: cycle %0d step_en=%b want 0", i, step_en);
      end
    end
    checks++;
    if (step_count !== '0) begin
      failures++;
      $display("FAIL held_step_count: got %0d want 0", step_count);
    end
    btn_step = 0; tick();
  endtask

  task automatic test_single_step();
    int base = m_count;
    for (int p = 0; p < 3; p++) begin
      btn_step = 1; tick();
      checks++;
      if (step_en !== 1'b1) begin
        failures++;
        $display("FAIL single_step_pulse: press %0d step_en=%b want 1", p, step_en);
      end
      tick();
      checks++;
      if (step_en !== 1'b0) begin
        failures++;
        $display("FAIL single_step_width: press %0d step_en=%b want 0", p, step_en);
      end
      btn_step = 0; tick(); tick();
    end
    checks++;
    if (int'(step_count) !== (base + 3) % CMAX) begin
      failures++;
      $display("FAIL single_step_count: got %0d want %0d", step_count, (base + 3) % CMAX);
    end
  endtask

  task automatic test_run();
    int ticks = 0;
    int base = m_count;
    bit exp, bad;
    btn_run = 1; tick(); btn_run = 0;
    checks++;
    if (running !== 1'b1) begin
      failures++;
      $display("FAIL run_enter: running=%b want 1", running);
    end
    for (int cyc = 0; cyc < 300; cyc++) begin
      clken = (cyc % 4 == 3);
      tick();
      if (clken) ticks++;
      exp = clken && (ticks % RUN_DIV == 0);
      checks++;
      if (step_en !== exp) begin
        failures++;
        $display("FAIL run_cadence: tick %0d step_en=%b want %b", ticks, step_en, exp);
      end
    end
    clken = 0;
    checks++;
    if (int'(step_count) !== (base + 3) % CMAX) begin
      failures++;
      $display("FAIL run_count: got %0d want %0d", step_count, (base + 3) % CMAX);
    end
    btn_run = 1; tick(); btn_run = 0;
    bad = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      clken = (cyc % 4 == 3);
      tick();
      if (step_en !== 1'b0 || running !== 1'b0) bad = 1;
    end
    clken = 0;
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL run_pause: step_en/running seen high after pause (running=%b) want 0", running);
    end
  endtask

  task automatic test_breakpoint();
    int base = m_count;
    int n = 0;
    bkpt_en = 1; bkpt_addr = 5; halt_mask = 0; flags = 0; endereco = 5;
    btn_run = 1; tick(); btn_run = 0;
    clken = 1;
    while (halted !== 1'b1 && n < 2000) begin
      endereco = ADDR_W'(m_count - base + 5);
      tick();
      n++;
    end
    clken = 0;
    checks++;
    if (halted !== 1'b1 || running !== 1'b0) begin
      failures++;
      $display("FAIL bkpt_halt: halted=%b running=%b after %0d cycles, want 1/0", halted, running, n);
    end
    checks++;
    if (int'(step_count) !== (base + 32) % CMAX || step_en !== 1'b0) begin
      failures++;
      $display("FAIL bkpt_steps: count=%0d step_en=%b want %0d/0", step_count, step_en,
               (base + 32) % CMAX);
    end
    bkpt_en = 0;
  endtask

  task automatic test_flag_halt();
    int n = 0, cyc = 0;
    int base;
    bit bad = 0;
    halt_mask = 4'b0001; flags = 0;
    btn_run = 1; tick(); btn_run = 0;
    base = m_count;
    clken = 1;
    while (n < 2 && cyc < 200) begin
      tick(); cyc++;
      if (step_en === 1'b1) n++;
    end
    flags = 4'b0001;
    tick();
    checks++;
    if (halted !== 1'b1 || step_en !== 1'b0) begin
      failures++;
      $display("FAIL flag_halt: halted=%b step_en=%b want 1/0", halted, step_en);
    end
    for (int i = 0; i < 60; i++) begin
      tick();
      if (step_en !== 1'b0) bad = 1;
    end
    clken = 0;
    checks++;
    if (bad || int'(step_count) !== (base + 2) % CMAX) begin
      failures++;
      $display("FAIL flag_no_third: count=%0d want %0d", step_count, (base + 2) % CMAX);
    end
    btn_step = 1; tick();
    checks++;
    if (step_en !== 1'b1 || halted !== 1'b0 || running !== 1'b0) begin
      failures++;
      $display("FAIL halt_step: step_en=%b halted=%b running=%b want 1/0/0", step_en, halted, running);
    end
    btn_step = 0; tick();
    checks++;
    if (step_en !== 1'b0) begin
      failures++;
      $display("FAIL halt_step_width: step_en=%b want 0", step_en);
    end
  endtask

  task automatic test_simultaneous();
    int n = 0;
    halt_mask = 4'b0001; flags = 4'b0001;
    btn_run = 1; tick(); btn_run = 0;
    clken = 1;
    while (halted !== 1'b1 && n < 200) begin tick(); n++; end
    clken = 0;
    checks++;
    if (halted !== 1'b1) begin
      failures++;
      $display("FAIL simul_setup: halted=%b want 1", halted);
    end
    btn_step = 1; btn_run = 1; tick();
    checks++;
    if (running !== 1'b1 || step_en !== 1'b0) begin
      failures++;
      $display("FAIL simul_run_wins: running=%b step_en=%b want 1/0", running, step_en);
    end
    btn_step = 0; btn_run = 0; flags = 0; halt_mask = 0; tick();
    checks++;
    if (step_en !== 1'b0) begin
      failures++;
      $display("FAIL simul_no_step: step_en=%b want 0", step_en);
    end
    btn_run = 1; tick(); btn_run = 0; tick();
  endtask

  task automatic test_wrap();
    int n = 0;
    while (m_count != CMAX - 1 && n < 600) begin
      btn_step = 1; tick(); btn_step = 0; tick(); n++;
    end
    checks++;
    if (int'(step_count) !== CMAX - 1) begin
      failures++;
      $display("FAIL wrap_pre: count=%0d want %0d", step_count, CMAX - 1);
    end
    btn_step = 1; tick();
    checks++;
    if (step_count !== '0 || step_en !== 1'b1) begin
      failures++;
      $display("FAIL wrap: count=%0d step_en=%b want 0/1", step_count, step_en);
    end
    btn_step = 0; tick();
  endtask

  task automatic test_random();
    int off = $urandom_range(0, 31);
    bit prev_en = 0;
    bkpt_addr = ADDR_W'($urandom_range(0, 31));
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0)  btn_step = ~btn_step;
      if ($urandom_range(0, 39) == 0) btn_run = ~btn_run;
      if ($urandom_range(0, 15) == 0) flags = 4'($urandom);
      if ($urandom_range(0, 99) == 0) halt_mask = 4'($urandom);
      if ($urandom_range(0, 99) == 0) bkpt_en = ~bkpt_en;
      clken    = ($urandom_range(0, 1) == 1);
      reset    = ($urandom_range(0, 499) == 0);
      endereco = ADDR_W'(m_count + off);
      tick();
      checks++;
      if (step_en !== m_en || running !== (m_mode == 1) || halted !== (m_mode == 2) ||
          int'(step_count) !== m_count) begin
        failures++;
        if (failures < 30)
          $display("FAIL random_model: cyc %0d en/run/halt/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d",
                   i, step_en, running, halted, step_count, m_en, m_mode == 1, m_mode == 2, m_count);
      end
      checks++;
      if (prev_en && step_en === 1'b1) begin
        failures++;
        if (failures < 30) $display("FAIL random_back_to_back: cyc %0d step_en=1 twice, want 0", i);
      end
      prev_en = (step_en === 1'b1);
    end
    reset = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_step();
    test_run();
    test_breakpoint();
    test_flag_halt();
    test_simultaneous();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/step_ctrl.md
Name: step_ctrl

Overview:
- Execution controller that sits directly upstream of the datapath/ROM stage.
- Converts the debounced step and run buttons into a one-cycle step_en strobe that drives the datapath clock enable. This replaces wiring the raw debounced level straight to the datapath.
- Supports single-step, free-run at a divided rate, a breakpoint on the program address (endereco), and halt on selected FLAGS bits.
- Step counter output is provided for the 7-segment display.

Parameters:
- ADDR_W, 5, width of program address (endereco).
- CNT_W, 16, width of step counter.
- RUN_DIV, 25, number of clken ticks between steps in RUN mode (4 steps/s with 100 Hz clken).

Ports:
- clock, input, 1, master clock (100 MHz).
- reset, input, 1, synchronous, active-high reset.
- clken, input, 1, one-cycle tick (100 Hz) from the debounce block.
- btn_step, input, 1, debounced step button level.
- btn_run, input, 1, debounced run/pause button level.
- endereco, input, ADDR_W, current program address from the datapath.
- flags, input, 4, datapath FLAGS {O,C,S,Z}.
- halt_mask, input, 4, a FLAGS bit set here halts RUN.
- bkpt_en, input, 1, breakpoint enable.
- bkpt_addr, input, ADDR_W, breakpoint address.
- step_en, output, 1, one-cycle datapath clock enable.
- running, output, 1, high in RUN.
- halted, output, 1, high in HALT.
- step_count, output, CNT_W, number of steps issued.

Behaviour:
- Reset (sync, active-high, priority over everything):
  - state = IDLE; step_en, running, halted = 0; step_count = 0; divider = 0; armed = 0.
  - Edge registers load the current btn_step/btn_run, so a button held through reset causes no step.
- Edge detection: step_rise = btn_step & ~btn_step_q; run_rise = btn_run & ~btn_run_q. Edge registers update every cycle.
- step_en is registered: high exactly one cycle, in the cycle after the triggering event. Never high two consecutive cycles.
- stop_hit = armed & ((bkpt_en & endereco==bkpt_addr) | |(flags & halt_mask)).
- IDLE state:
  - run_rise -> RUN; divider = 0; armed = 0.
  - Otherwise step_rise -> step_en pulse, stay IDLE.
- RUN state (running = 1):
  - Priority 1: run_rise -> IDLE (pause), no step.
  - Priority 2: stop_hit -> HALT, no step issued that cycle.
  - Priority 3: on clken, if divider == RUN_DIV-1, then step_en pulse, divider = 0, armed = 1. Otherwise on clken, divider + 1.
  - step_rise is ignored in RUN.
- HALT state (halted = 1; holds until a button edge):
  - run_rise -> RUN; divider = 0; armed = 0.
  - Otherwise step_rise -> step_en pulse -> IDLE.
- Simultaneous step_rise and run_rise in IDLE or HALT: run wins, step is discarded.
- armed = 0 on entry to RUN, so the first run step always executes even if the current address equals bkpt_addr or a masked flag is already set.
  - armed becomes 1 on the first step issued in RUN.
  - stop_hit is evaluated every cycle after that, using endereco/flags as they stand (already updated by the previous step).
- step_count increments in the same cycle step_en is high and wraps 2^CNT_W-1 -> 0. Cleared only by reset.
- halt_mask = 0 and bkpt_en = 0 means RUN only stops via run_rise.

Test Plan:
- Reset with btn_step held high, release reset, keep btn_step high 10 cycles -> step_en never asserts, step_count = 0.
- In IDLE, three separate btn_step presses -> exactly three 1-cycle step_en pulses, each 1 cycle after its rising edge; step_count = 3.
- btn_run press, clken every 4 cycles -> first step_en at the 25th clken tick, then every 25 ticks. A second btn_run press -> IDLE, no further pulses, running = 0.
- bkpt_en = 1, bkpt_addr = 5, endereco modelled as step_count[4:0], start RUN at endereco = 5 -> first step executes (armed logic). Halts on return to address 5 after 32 steps; halted = 1, step_count = 32.
- halt_mask = 4'b0001, assert flags Z after the 2nd run step -> HALT the next cycle, no 3rd step. Then a step_rise -> one pulse and IDLE.
- In HALT, btn_step and btn_run rise in the same cycle -> RUN entered, no step_en that cycle. step_count at 2^16-1 plus one step -> wraps to 0.
